// File: rtl/var_bw_add_sched.sv
// Two-requester scheduler feeding one shared 16-bit / dual 8-bit adder.
// Both-8-bit requests are packed into one parallel add; otherwise round-robin.
module var_bw_add_sched #(
  parameter int CNT_W   = 16,
  parameter bit RR_INIT = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic             req0_mode,
  input  logic [15:0]      req0_a,
  input  logic [15:0]      req0_b,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic             req1_mode,
  input  logic [15:0]      req1_a,
  input  logic [15:0]      req1_b,
  output logic             rsp0_valid,
  input  logic             rsp0_ready,
  output logic [16:0]      rsp0_sum,
  output logic             rsp1_valid,
  input  logic             rsp1_ready,
  output logic [16:0]      rsp1_sum,
  output logic [CNT_W-1:0] pack_cnt
);

  logic             r_rr;
  logic             r_vld0, r_vld1;
  logic [16:0]      r_sum0, r_sum1;
  logic [CNT_W-1:0] r_cnt;

  logic        w_e0, w_e1, w_pack, w_g0, w_g1, w_sel1, w_m8, w_cin;
  logic [15:0] w_a, w_b;
  logic [8:0]  w_lo, w_hi;
  logic [16:0] w_single;

  assign w_e0   = req0_valid & (~r_vld0 | rsp0_ready);
  assign w_e1   = req1_valid & (~r_vld1 | rsp1_ready);
  assign w_pack = w_e0 & w_e1 & req0_mode & req1_mode;
  assign w_g0   = w_e0 & (w_pack | ~w_e1 | ~r_rr);
  assign w_g1   = w_e1 & (w_pack | ~w_e0 | r_rr);
  assign w_sel1 = w_g1 & ~w_g0;
  assign w_m8   = w_sel1 ? req1_mode : req0_mode;

  // Packed issue places req0 bytes in the low lane and req1 bytes in the high lane.
  always_comb begin
    w_a = w_sel1 ? req1_a : req0_a;
    w_b = w_sel1 ? req1_b : req0_b;
    if (w_pack) begin
      w_a = {req1_a[7:0], req0_a[7:0]};
      w_b = {req1_b[7:0], req0_b[7:0]};
    end
  end

  // Lane carry only crosses the byte boundary in 16-bit mode.
  assign w_lo     = {1'b0, w_a[7:0]} + {1'b0, w_b[7:0]};
  assign w_cin    = ~w_m8 & w_lo[8];
  assign w_hi     = {1'b0, w_a[15:8]} + {1'b0, w_b[15:8]} + {8'b0, w_cin};
  assign w_single = w_m8 ? {8'b0, w_lo} : {w_hi, w_lo[7:0]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rr   <= RR_INIT;
      r_vld0 <= 1'b0;
      r_vld1 <= 1'b0;
      r_sum0 <= '0;
      r_sum1 <= '0;
      r_cnt  <= '0;
    end else begin
      if (w_g0) begin
        r_vld0 <= 1'b1;
        r_sum0 <= w_single;
      end else if (rsp0_ready) begin
        r_vld0 <= 1'b0;
      end
      if (w_g1) begin
        r_vld1 <= 1'b1;
        r_sum1 <= w_pack ? {8'b0, w_hi} : w_single;
      end else if (rsp1_ready) begin
        r_vld1 <= 1'b0;
      end
      if (!w_pack) begin
        if (w_e0 && w_e1) r_rr <= ~r_rr;
        else if (w_e0)    r_rr <= 1'b1;
        else if (w_e1)    r_rr <= 1'b0;
      end
      if (w_pack && (r_cnt != '1))
        r_cnt <= r_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  assign req0_ready = w_g0;
  assign req1_ready = w_g1;
  assign rsp0_valid = r_vld0;
  assign rsp1_valid = r_vld1;
  assign rsp0_sum   = r_sum0;
  assign rsp1_sum   = r_sum1;
  assign pack_cnt   = r_cnt;

endmodule

// File: tb/tb_var_bw_add_sched.sv
// Randomized bench for var_bw_add_sched against a cycle-level behavioural model.
module tb_var_bw_add_sched;
  localparam int CNT_W = 3;
  localparam int CMAX  = (1 << CNT_W) - 1;

  logic clk = 1'b0, rst_n = 1'b0;
  logic req0_valid = 0, req0_ready, req0_mode = 0, req1_valid = 0, req1_ready, req1_mode = 0;
  logic [15:0] req0_a = 0, req0_b = 0, req1_a = 0, req1_b = 0;
  logic rsp0_valid, rsp0_ready = 0, rsp1_valid, rsp1_ready = 0;
  logic [16:0] rsp0_sum, rsp1_sum;
  logic [CNT_W-1:0] pack_cnt;

  var_bw_add_sched #(.CNT_W(CNT_W), .RR_INIT(1'b0)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_mode(req0_mode),
    .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_mode(req1_mode),
    .req1_a(req1_a), .req1_b(req1_b),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_sum(rsp0_sum),
    .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_sum(rsp1_sum),
    .pack_cnt(pack_cnt));

  always #5 clk = ~clk;

  int checks = 0, failures = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h @%0t", name, got, exp, $time);
    end
  endtask

  function automatic logic [16:0] mres(input logic m, input logic [15:0] a, input logic [15:0] b);
    if (m) return {9'b0, a[7:0]} + {9'b0, b[7:0]};
    return {1'b0, a} + {1'b0, b};
  endfunction

  // Model: result slots, favoured requester, pack count; acc[] tells the driver what was taken.
  logic        m_vld[2];
  logic [16:0] m_sum[2];
  int          m_rr, m_cnt;
  logic        acc[2];

  always @(negedge clk or negedge rst_n) begin
    logic e[2], g[2], v[2], m[2], rdy[2], pk;
    logic [15:0] a[2], b[2];
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin m_vld[i] = 0; m_sum[i] = '0; acc[i] = 0; end
      m_rr = 0; m_cnt = 0;
    end else begin
      v = '{req0_valid, req1_valid}; m = '{req0_mode, req1_mode};
      a = '{req0_a, req1_a}; b = '{req0_b, req1_b}; rdy = '{rsp0_ready, rsp1_ready};
      for (int i = 0; i < 2; i++) e[i] = v[i] && (!m_vld[i] || rdy[i]);
      pk = e[0] && e[1] && m[0] && m[1];
      if (e[0] && e[1] && !pk) begin g[0] = (m_rr == 0); g[1] = (m_rr == 1); end
      else g = e;
      chk("req0_ready", req0_ready, g[0]);
      chk("req1_ready", req1_ready, g[1]);
      chk("rsp0_valid", rsp0_valid, m_vld[0]);
      chk("rsp1_valid", rsp1_valid, m_vld[1]);
      chk("rsp0_sum", rsp0_sum, m_sum[0]);
      chk("rsp1_sum", rsp1_sum, m_sum[1]);
      chk("pack_cnt", pack_cnt, m_cnt);
      for (int i = 0; i < 2; i++) begin
        if (g[i]) begin m_vld[i] = 1; m_sum[i] = mres(m[i], a[i], b[i]); end
        else if (rdy[i]) m_vld[i] = 0;
        acc[i] = g[i];
      end
      if (!pk) begin
        if (e[0] && e[1]) m_rr = 1 - m_rr;
        else if (e[0])    m_rr = 1;
        else if (e[1])    m_rr = 0;
      end
      if (pk && m_cnt < CMAX) m_cnt++;
    end
  end

  // Driver state: a requester holds its op until the cycle it is accepted.
  logic        cv[2], cm[2];
  logic [15:0] ca[2], cb[2];
  int pv = 0, pm = 0, pr0 = 100, pr1 = 100;

  task automatic apply();
    req0_valid = cv[0]; req0_mode = cm[0]; req0_a = ca[0]; req0_b = cb[0];
    req1_valid = cv[1]; req1_mode = cm[1]; req1_a = ca[1]; req1_b = cb[1];
  endtask

  task automatic step();
    @(posedge clk); #1;
    for (int i = 0; i < 2; i++)
      if (!(cv[i] && !acc[i])) begin
        cv[i] = ($urandom_range(99) < pv);
        cm[i] = ($urandom_range(99) < pm);
        ca[i] = 16'($urandom); cb[i] = 16'($urandom);
      end
    rsp0_ready = ($urandom_range(99) < pr0);
    rsp1_ready = ($urandom_range(99) < pr1);
    apply();
  endtask

  task automatic dir(input logic v0, input logic m0, input logic [15:0] a0, input logic [15:0] b0,
                     input logic v1, input logic m1, input logic [15:0] a1, input logic [15:0] b1);
    @(posedge clk); #1;
    cv = '{v0, v1}; cm = '{m0, m1}; ca = '{a0, a1}; cb = '{b0, b1};
    rsp0_ready = 1; rsp1_ready = 1;
    apply();
  endtask

  initial begin
    cv = '{0, 0}; cm = '{0, 0}; ca = '{0, 0}; cb = '{0, 0};
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;

    // Single 16-bit op with full carry-out.
    dir(1, 0, 16'hFFFF, 16'h0001, 0, 0, 16'h0, 16'h0);
    @(negedge clk); #1;
    chk("lit_single_rdy0", req0_ready, 1'b1);
    chk("lit_single_rdy1", req1_ready, 1'b0);
    dir(0, 0, 16'h0, 16'h0, 0, 0, 16'h0, 16'h0);
    @(negedge clk); #1;
    chk("lit_single_vld", rsp0_valid, 1'b1);
    chk("lit_single_sum", rsp0_sum, 17'h10000);
    chk("lit_single_cnt", pack_cnt, 0);

    // Packed pair with garbage upper bytes.
    dir(1, 1, 16'hAAFF, 16'hAA01, 1, 1, 16'hAA80, 16'hAA80);
    @(negedge clk); #1;
    chk("lit_pack_rdy", {req0_ready, req1_ready}, 2'b11);
    dir(0, 0, 16'h0, 16'h0, 0, 0, 16'h0, 16'h0);
    @(negedge clk); #1;
    chk("lit_pack_sum0", rsp0_sum, 17'h100);
    chk("lit_pack_sum1", rsp1_sum, 17'h100);
    chk("lit_pack_cnt", pack_cnt, 1);

    // rr points at req1 after the lone req0 issue; pack must not have moved it.
    dir(1, 0, 16'h1234, 16'h1111, 1, 0, 16'h8000, 16'h8000);
    @(negedge clk); #1;
    chk("lit_rr_after_pack", {req1_ready, req0_ready}, 2'b10);
    pv = 100; pm = 0; pr0 = 100; pr1 = 100;
    repeat (4) step();

    // Backpressure on requester 0, then release.
    pr0 = 0;
    repeat (6) step();
    @(negedge clk); #1;
    chk("lit_bp_rdy0", req0_ready, 1'b0);
    pr0 = 100;
    repeat (6) step();

    // Mixed modes, then saturation of the narrow counter.
    pm = 50; repeat (10) step();
    pm = 100; repeat (8) step();
    pv = 0; step();
    @(negedge clk); #1;
    chk("lit_sat_cnt", pack_cnt, CMAX);

    for (int ph = 0; ph < 20; ph++) begin
      pv = $urandom_range(30, 100); pm = $urandom_range(0, 100);
      pr0 = $urandom_range(0, 100); pr1 = $urandom_range(0, 100);
      repeat (100) step();
    end

    // Asynchronous reset mid-stream.
    pv = 100; pm = 100; pr0 = 50; pr1 = 50;
    repeat (5) step();
    @(posedge clk); #2;
    rst_n = 1'b0;
    cv = '{0, 0}; apply();
    #1;
    chk("lit_rst_vld0", rsp0_valid, 1'b0);
    chk("lit_rst_vld1", rsp1_valid, 1'b0);
    chk("lit_rst_cnt", pack_cnt, 0);
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;

    for (int ph = 0; ph < 10; ph++) begin
      pv = $urandom_range(30, 100); pm = $urandom_range(0, 100);
      pr0 = $urandom_range(0, 100); pr1 = $urandom_range(0, 100);
      repeat (100) step();
    end
    @(negedge clk); #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
